// File: rtl/universal_shift_reg_if.sv
// rtl/universal_shift_reg_if.sv - control/data bundle for the universal shift register
//
// Purpose: groups the load, operation-request, serial-input and status
// signals of universal_shift_reg so they travel as one port.
// Ports (as seen from the register, slave modport):
//   L      in   parallel load request (highest priority after reset)
//   R      in   N-bit parallel load data
//   Mode   in   3-bit operation select, captured on Start
//   Amt    in   CW-bit step count, captured on Start
//   Start  in   begin operation (IDLE only, L=0)
//   WL     in   serial bit entering bit 0 on shift left
//   WR     in   serial bit entering bit N-1 on shift right
//   Q      out  register contents
//   SOut   out  last bit shifted/rotated out
//   Busy   out  high while stepping
//   Done   out  one-cycle completion pulse
interface universal_shift_reg_if #(
    parameter int N  = 16,
    parameter int CW = 4
);
    logic          L;
    logic [N-1:0]  R;
    logic [2:0]    Mode;
    logic [CW-1:0] Amt;
    logic          Start;
    logic          WL;
    logic          WR;
    logic [N-1:0]  Q;
    logic          SOut;
    logic          Busy;
    logic          Done;

    modport master (
        output L, R, Mode, Amt, Start, WL, WR,
        input  Q, SOut, Busy, Done
    );

    modport slave (
        input  L, R, Mode, Amt, Start, WL, WR,
        output Q, SOut, Busy, Done
    );
endinterface

// File: rtl/universal_shift_reg.sv
// rtl/universal_shift_reg.sv - N-bit universal shift register with multi-step sequencer
//
// Purpose: parallel load, logical shift left/right, rotate left/right and
// arithmetic shift right, performed one bit position per clock for a
// captured step count, with Busy/Done handshake.
// Ports:
//   Clk     in   clock, rising edge
//   Resetn  in   synchronous active-low reset
//   bus     slave modport of universal_shift_reg_if (see that file)
module universal_shift_reg #(
    parameter int N  = 16,
    parameter int CW = 4
) (
    input  logic                 Clk,
    input  logic                 Resetn,
    universal_shift_reg_if.slave bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    mode_q;
    logic [N-1:0]  q_r;
    logic          sout_r;
    logic          busy_r;
    logic          done_r;

    logic [N-1:0]  q_step;
    logic          sout_step;

    assign bus.Q    = q_r;
    assign bus.SOut = sout_r;
    assign bus.Busy = busy_r;
    assign bus.Done = done_r;

    // One single-bit step of the captured operation. WL/WR are taken live.
    always_comb begin
        q_step    = q_r;
        sout_step = sout_r;
        case (mode_q)
            3'b001: begin
                q_step    = {bus.WR, q_r[N-1:1]};
                sout_step = q_r[0];
            end
            3'b010: begin
                q_step    = {q_r[N-2:0], bus.WL};
                sout_step = q_r[N-1];
            end
            3'b011: begin
                q_step    = {q_r[0], q_r[N-1:1]};
                sout_step = q_r[0];
            end
            3'b100: begin
                q_step    = {q_r[N-2:0], q_r[N-1]};
                sout_step = q_r[N-1];
            end
            3'b101: begin
                q_step    = {q_r[N-1], q_r[N-1:1]};
                sout_step = q_r[0];
            end
            default: begin
                q_step    = q_r;
                sout_step = sout_r;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Resetn) begin
            state  <= IDLE;
            cnt    <= '0;
            mode_q <= 3'b000;
            q_r    <= '0;
            sout_r <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else if (bus.L) begin
            // Load aborts any running operation without a Done pulse.
            q_r    <= bus.R;
            state  <= IDLE;
            busy_r <= 1'b0;
            cnt    <= '0;
            done_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.Start) begin
                        if (bus.Amt != '0) begin
                            mode_q <= bus.Mode;
                            cnt    <= bus.Amt;
                            state  <= SHIFT;
                            busy_r <= 1'b1;
                        end else begin
                            // Zero-length request completes immediately.
                            done_r <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    q_r    <= q_step;
                    sout_r <= sout_step;
                    cnt    <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        // Final step: Done lines up with the final Q.
                        state  <= IDLE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end else begin
                        done_r <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_universal_shift_reg.sv
// tb/tb_universal_shift_reg.sv - scoreboard bench for universal_shift_reg
module tb_universal_shift_reg;

    localparam int N    = 8;
    localparam int CW   = 4;
    localparam int FULL = 1 << N;
    localparam int HALF = 1 << (N - 1);

    logic Clk    = 1'b0;
    logic Resetn = 1'b0;

    always #5 Clk = ~Clk;

    universal_shift_reg_if #(.N(N), .CW(CW)) bus ();

    universal_shift_reg #(.N(N), .CW(CW)) dut (
        .Clk    (Clk),
        .Resetn (Resetn),
        .bus    (bus)
    );

    typedef struct {
        int q;
        int sout;
        int steps;
    } exp_t;

    exp_t sb[$];

    int n_cmp    = 0;
    int n_err    = 0;
    int busy_run = 0;

    // Model state of the register as the bench believes it to be.
    int cur_q = 0;
    int cur_s = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: applies 'amt' single-bit steps using integer arithmetic.
    function automatic void model(input int q0, input int s0, input int m,
                                  input int amt, input int wl, input int wr,
                                  output int q, output int s);
        int lo;
        int hi;
        q = q0;
        s = s0;
        for (int i = 0; i < amt; i++) begin
            lo = q % 2;
            hi = q / HALF;
            case (m)
                1: begin s = lo; q = q / 2 + wr * HALF; end
                2: begin s = hi; q = (q * 2) % FULL + wl; end
                3: begin s = lo; q = q / 2 + lo * HALF; end
                4: begin s = hi; q = (q * 2) % FULL + hi; end
                5: begin s = lo; q = q / 2 + hi * HALF; end
                default: ;
            endcase
        end
    endfunction

    // Monitor: pops and compares on every Done; also counts Busy cycles.
    always @(negedge Clk) begin
        exp_t e;
        if (bus.Done === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got Done=1 expected no Done (q=%0h)", bus.Q);
            end else begin
                e = sb.pop_front();
                check("done_q", int'(bus.Q), e.q);
                check("done_sout", int'(bus.SOut), e.sout);
                check("busy_cycles", busy_run, e.steps);
            end
            busy_run = 0;
        end else if (bus.Busy === 1'b1) begin
            busy_run++;
        end else begin
            busy_run = 0;
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic load(input int r);
        bus.L = 1'b1;
        bus.R = N'(r);
        tick();
        bus.L = 1'b0;
        cur_q = r;
    endtask

    task automatic issue(input int m, input int amt, input int wl, input int wr);
        exp_t e;
        int q;
        int s;
        model(cur_q, cur_s, m, amt, wl, wr, q, s);
        e.q     = q;
        e.sout  = s;
        e.steps = amt;
        sb.push_back(e);
        cur_q = q;
        cur_s = s;
        bus.Mode  = 3'(m);
        bus.Amt   = CW'(amt);
        bus.WL    = wl[0];
        bus.WR    = wr[0];
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
    endtask

    // Full operation; 'disturb' re-asserts Start and alters Mode/Amt mid-run.
    task automatic run_op(input int m, input int amt, input int wl, input int wr,
                          input bit disturb);
        issue(m, amt, wl, wr);
        for (int i = 0; i < amt; i++) begin
            if (disturb && i == 0) begin
                bus.Start = 1'b1;
                bus.Mode  = 3'(m ^ 3);
                bus.Amt   = CW'($urandom_range(1, 15));
            end
            tick();
            bus.Start = 1'b0;
        end
        tick();
    endtask

    initial begin
        int q;
        int s;
        bus.L     = 1'b0;
        bus.R     = '0;
        bus.Mode  = 3'b000;
        bus.Amt   = '0;
        bus.Start = 1'b0;
        bus.WL    = 1'b0;
        bus.WR    = 1'b0;

        // Reset wins over a simultaneous load.
        Resetn = 1'b0;
        bus.L  = 1'b1;
        bus.R  = 8'hFF;
        tick();
        tick();
        check("reset_q", int'(bus.Q), 0);
        check("reset_busy", int'(bus.Busy), 0);
        check("reset_done", int'(bus.Done), 0);
        check("reset_sout", int'(bus.SOut), 0);
        bus.L  = 1'b0;
        Resetn = 1'b1;
        cur_q  = 0;
        cur_s  = 0;

        load(8'hA5);
        check("load_a5", int'(bus.Q), 8'hA5);

        // Shift right by 3 with WR=1, checked step by step.
        issue(1, 3, 0, 1);
        check("sr_busy0", int'(bus.Busy), 1);
        tick();
        check("sr_q1", int'(bus.Q), 8'hD2);
        check("sr_s1", int'(bus.SOut), 1);
        tick();
        check("sr_q2", int'(bus.Q), 8'hE9);
        check("sr_s2", int'(bus.SOut), 0);
        tick();
        check("sr_q3", int'(bus.Q), 8'hF4);
        check("sr_s3", int'(bus.SOut), 1);
        check("sr_done", int'(bus.Done), 1);
        tick();
        check("sr_done_gone", int'(bus.Done), 0);

        // Rotate left past N wraps around.
        load(8'h81);
        run_op(4, 9, 0, 0, 1'b0);
        check("rol9_q", int'(bus.Q), 8'h03);

        // Arithmetic right keeps the sign bit.
        load(8'h90);
        run_op(5, 2, 0, 0, 1'b0);
        check("asr2_q", int'(bus.Q), 8'hE4);

        // Zero count: Done next cycle, never Busy.
        issue(1, 0, 1, 1);
        check("amt0_busy", int'(bus.Busy), 0);
        check("amt0_done", int'(bus.Done), 1);
        tick();

        // Start during Busy plus Mode change mid-run: captured mode continues.
        load(8'h5A);
        run_op(1, 4, 1, 0, 1'b1);

        // Load aborts shift left after 2 steps: no Done, SOut kept.
        load(8'hC3);
        model(cur_q, cur_s, 2, 2, 1, 0, q, s);
        bus.Mode  = 3'b010;
        bus.Amt   = 4'd5;
        bus.WL    = 1'b1;
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        tick();
        tick();
        load(8'h3C);
        cur_s = s;
        check("abort_q", int'(bus.Q), 8'h3C);
        check("abort_busy", int'(bus.Busy), 0);
        check("abort_sout", int'(bus.SOut), s);
        repeat (6) tick();

        // Reset aborts an operation.
        bus.Mode  = 3'b010;
        bus.Amt   = 4'd5;
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        tick();
        tick();
        Resetn = 1'b0;
        tick();
        Resetn = 1'b1;
        cur_q  = 0;
        cur_s  = 0;
        check("rst_abort_q", int'(bus.Q), 0);
        check("rst_abort_sout", int'(bus.SOut), 0);
        check("rst_abort_busy", int'(bus.Busy), 0);
        repeat (6) tick();

        // Reserved mode acts as hold but still sequences.
        load(8'h6B);
        run_op(6, 2, 1, 1, 1'b0);
        check("hold110_q", int'(bus.Q), 8'h6B);

        // Randomised operations.
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 3) == 0)
                load(int'($urandom_range(0, FULL - 1)));
            run_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                   bit'($urandom_range(0, 1)));
        end

        repeat (3) tick();
        check("scoreboard_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/universal_shift_reg.md
Name: universal_shift_reg

Overview:
- Parametrised n-bit universal shift register, the successor to the team's single-direction load/shift register.
- Supports parallel load, logical shift left/right, rotate left/right and arithmetic shift right.
- Multi-step operations are sequenced by a small FSM: one bit position per clock for a requested count, with Busy/Done handshake.
- Sits in datapath blocks needing serial/parallel conversion or multi-cycle shifts (e.g. shift-add multipliers).

Parameters:
N, 16, register width in bits (N >= 2)
CW, 4, width of shift-count input Amt; max count 2^CW-1 (counts > N permitted)

Ports:
Clk  input  1  clock, all state updates on rising edge
Resetn  input  1  synchronous active-low reset, sampled on rising edge of Clk
L  input  1  parallel load request; highest priority
R  input  N  parallel load data
Mode  input  3  operation select, captured on Start
Amt  input  CW  number of single-bit steps, captured on Start
Start  input  1  begin operation; honoured only in IDLE with L=0
WL  input  1  serial input entering bit 0 on shift left
WR  input  1  serial input entering bit N-1 on shift right
Q  output  N  register contents
SOut  output  1  last bit shifted/rotated out
Busy  output  1  high while in SHIFT state
Done  output  1  one-cycle pulse on completion

Behaviour:
- Reset (Resetn=0 at edge): Q=0, SOut=0, Busy=0, Done=0, state=IDLE, internal count=0, captured mode=000. Reset overrides L and Start, including mid-operation.
- States: IDLE, SHIFT. Busy = (state==SHIFT), registered.
- Mode encoding, one step:
  - 000 hold.
  - 001 shift right: Q <= {WR, Q[N-1:1]}; SOut <= Q[0].
  - 010 shift left: Q <= {Q[N-2:0], WL}; SOut <= Q[N-1].
  - 011 rotate right: Q <= {Q[0], Q[N-1:1]}; SOut <= Q[0].
  - 100 rotate left: Q <= {Q[N-2:0], Q[N-1]}; SOut <= Q[N-1].
  - 101 arithmetic right: Q <= {Q[N-1], Q[N-1:1]}; SOut <= Q[0].
  - 110, 111 treated as hold; SOut unchanged.
- Priority every edge: Resetn low > L > Start/SHIFT stepping.
- L=1 in any state: Q <= R, state <= IDLE, Busy <= 0, count cleared, Done=0 that cycle (abort, no Done pulse), SOut unchanged.
- IDLE, L=0, Start=1:
  - Amt>0: capture Mode and Amt; state <= SHIFT; no step this edge.
  - Amt=0: no state change; Done pulses next cycle; Q unchanged.
- SHIFT: one step per edge using the captured mode; count decrements. On the edge performing the final step, state <= IDLE and Done <= 1 (Done is high the cycle after the last step, aligned with final Q). Exactly Amt steps.
- Latency: Start at edge t -> steps at edges t+1..t+Amt -> Done high after edge t+Amt for one cycle; Busy high after edges t..t+Amt-1.
- Start while Busy: ignored. Mode, Amt and Start changes during SHIFT have no effect.
- WL/WR are sampled live at each step edge, not captured.
- Hold modes still run through SHIFT for Amt cycles and pulse Done.
- IDLE with no L or Start: Q, SOut hold; Done=0.

Test Plan:
- (N=8) Resetn=0 with L=1, R=8'hFF -> Q=00, Busy=0, Done=0, SOut=0. Release reset, L=1, R=8'hA5 -> Q=A5 next cycle.
- Q=A5, Mode=001, Amt=3, WR=1, Start -> Busy for 3 cycles, Q sequence D2, E9, F4, SOut=1,0,1, Done one cycle with Q=F4.
- Q=81, Mode=100, Amt=9 -> Q=03 at completion (rotate wraps past N), Done single pulse. Repeat with Mode=101, Q=90, Amt=2 -> Q=E4.
- Start with Amt=0 -> Q unchanged, Busy never high, Done pulses next cycle. Start asserted again during Busy -> ignored, step count unaffected.
- Mode=010, Amt=5, assert L with R=3C after 2 steps -> Q=3C, Busy=0, no Done ever. Repeat with Resetn=0 instead -> Q=00, SOut=0, IDLE.
- Mode=110, Amt=2 -> Q unchanged, Busy 2 cycles, Done pulses. Mode changed mid-SHIFT from 001 to 010 -> captured 001 continues.
